priority_encoder8_3: RTL and testbench

- Registered 8-to-3 priority encoder with pending-request capture and a VALID/READY output handshake.
- Collects one-hot or multi-hot request pulses on IN, holds them as pending bits, and presents one encoded index at a time on OUT.
- Clears each granted bit on acceptance.
- Sits upstream of the 3-to-8 decoders: it turns request lines back into a binary select, for example as an interrupt-index or channel-select source.

---
 rtl/priority_encoder8_3_pkg.sv | 19 +
 rtl/priority_encoder8_3_select.sv | 28 ++
 rtl/priority_encoder8_3.sv | 88 ++++++++
 tb/tb_priority_encoder8_3.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/priority_encoder8_3_pkg.sv
// Shared definitions for the 8-to-3 priority encoder and the 3-to-8 decoder family.
package priority_encoder8_3_pkg;

    localparam int IDX_W = 3;
    localparam int REQ_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic [REQ_W-1:0] onehot3(input logic [IDX_W-1:0] idx);
        logic [REQ_W-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/priority_encoder8_3_select.sv
// Combinational priority select: first set bit found walking away from i_start.
// PRIO_HIGH=1 walks downward (start-1, start-2, ...), PRIO_HIGH=0 walks upward; all wrap mod 8.
module pe8_select
    import priority_encoder8_3_pkg::*;
#(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic [REQ_W-1:0] i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [IDX_W-1:0] o_idx
);

    logic [REQ_W-1:0][IDX_W-1:0] w_cand;

    // w_cand[k] is the (k+1)-th index visited; the start index itself is visited last.
    for (genvar k = 0; k < REQ_W; k++) begin : g_cand
        assign w_cand[k] = PRIO_HIGH ? (i_start - IDX_W'(k + 1)) : (i_start + IDX_W'(k + 1));
    end

    // Scan lowest priority first so the earliest hit in search order wins.
    always_comb begin
        o_idx = '0;
        for (int k = REQ_W - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) o_idx = w_cand[k];
        end
    end

endmodule

// File: rtl/priority_encoder8_3.sv
// Registered 8-to-3 priority encoder with pending capture and VALID/READY output.
// Define ROUND_ROBIN_EN to rotate the search start past the last accepted grant.
module priority_encoder8_3
    import priority_encoder8_3_pkg::*;
#(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [REQ_W-1:0] IN,
    input  logic             EN,
    output logic [IDX_W-1:0] OUT,
    output logic             VALID,
    input  logic             READY,
    output logic [REQ_W-1:0] PEND
);

    state_t           r_state;
    state_t           w_state_next;
    logic [REQ_W-1:0] r_pend;
    logic [REQ_W-1:0] w_pend_next;
    logic [REQ_W-1:0] w_clr;
    logic [IDX_W-1:0] r_out;
    logic [IDX_W-1:0] w_sel;
    logic [IDX_W-1:0] w_start;
    logic             w_accept;
    logic             w_load;

    assign w_accept    = (r_state == ST_BUSY) && READY;
    assign w_clr       = w_accept ? onehot3(r_out) : '0;
    // Clear before set so a same-cycle re-request keeps the bit pending.
    assign w_pend_next = (r_pend & ~w_clr) | (EN ? IN : '0);

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_last;

    always_ff @(posedge CLK) begin
        if (RST)           r_last <= '0;
        else if (w_accept) r_last <= r_out;
    end

    assign w_start = r_last;
`else
    // Constant start that makes the rotating search degenerate to fixed priority.
    assign w_start = PRIO_HIGH ? IDX_W'(0) : IDX_W'(REQ_W - 1);
`endif

    pe8_select #(
        .PRIO_HIGH (PRIO_HIGH)
    ) u_select (
        .i_req   (r_pend),
        .i_start (w_start),
        .o_idx   (w_sel)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend != '0) begin
                    w_state_next = ST_BUSY;
                    w_load       = 1'b1;
                end
            end
            ST_BUSY: begin
                if (READY) w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
            if (w_load) r_out <= w_sel;
        end
    end

    assign OUT   = r_out;
    assign VALID = (r_state == ST_BUSY);
    assign PEND  = r_pend;

endmodule

// File: tb/tb_priority_encoder8_3.sv
// Scoreboard bench for priority_encoder8_3: expected grants queued at stimulus, popped on handshake.
module tb_priority_encoder8_3;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic [7:0] IN    = 8'h00;
    logic       EN    = 1'b0;
    logic       READY = 1'b0;
    logic [2:0] OUT;
    logic       VALID;
    logic [7:0] PEND;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [2:0] exp_q[$];

    priority_encoder8_3 #(.PRIO_HIGH(1'b1)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .IN    (IN),
        .EN    (EN),
        .OUT   (OUT),
        .VALID (VALID),
        .READY (READY),
        .PEND  (PEND)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Inputs change #1 after posedge, so at negedge VALID&&READY means an acceptance next edge.
    always @(negedge CLK) begin
        if (!RST && VALID && READY) begin
            if (exp_q.size() == 0) chk("sb_unexpected_grant", 32'(exp_q.size()), 32'd1);
            else                   chk("sb_grant", 32'(OUT), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        RST = 1'b1; IN = 8'hFF; EN = 1'b1; READY = 1'b0;
        tick(); tick();
        RST = 1'b0; IN = 8'h00; READY = 1'b1;
    endtask

    initial begin
        // Reset with all requests asserted
        do_reset();
        chk("rst_pend", 32'(PEND), 32'h00);
        chk("rst_valid", 32'(VALID), 32'd0);
        chk("rst_out", 32'(OUT), 32'd0);
        tick();
        chk("rel_pend", 32'(PEND), 32'h00);
        chk("rel_valid", 32'(VALID), 32'd0);

        // Single request
        IN = 8'h20; tick();
        chk("single_pend", 32'(PEND), 32'h20);
        chk("single_valid0", 32'(VALID), 32'd0);
        IN = 8'h00; exp_q.push_back(3'd5); tick();
        chk("single_valid1", 32'(VALID), 32'd1);
        chk("single_out", 32'(OUT), 32'd5);
        tick();
        chk("single_pend_clr", 32'(PEND), 32'h00);
        chk("single_valid_clr", 32'(VALID), 32'd0);

        // Fixed priority sweep
        do_reset();
        IN = 8'h85; tick();
        chk("fp_pend85", 32'(PEND), 32'h85);
        IN = 8'h00;
        exp_q.push_back(3'd7); exp_q.push_back(3'd2); exp_q.push_back(3'd0);
        tick(); chk("fp_out7", 32'(OUT), 32'd7);
        tick(); chk("fp_pend05", 32'(PEND), 32'h05);
        tick(); chk("fp_out2", 32'(OUT), 32'd2);
        tick(); chk("fp_pend01", 32'(PEND), 32'h01);
        tick(); chk("fp_out0", 32'(OUT), 32'd0);
        chk("fp_valid_out0", 32'(VALID), 32'd1);
        tick(); chk("fp_pend00", 32'(PEND), 32'h00);

        // Backpressure: OUT held while a higher-priority request arrives
        do_reset();
        READY = 1'b0; IN = 8'h06; tick();
        IN = 8'h00; tick();
        chk("bp_valid", 32'(VALID), 32'd1);
        chk("bp_out", 32'(OUT), 32'd2);
        IN = 8'h80; tick();
        IN = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_out", 32'(OUT), 32'd2);
        end
        chk("bp_pend86", 32'(PEND), 32'h86);
        exp_q.push_back(3'd2);
`ifdef ROUND_ROBIN_EN
        exp_q.push_back(3'd1); exp_q.push_back(3'd7);
`else
        exp_q.push_back(3'd7); exp_q.push_back(3'd1);
`endif
        READY = 1'b1; tick();
        chk("bp_pend82", 32'(PEND), 32'h82);
        chk("bp_valid_bubble", 32'(VALID), 32'd0);
        repeat (4) tick();
        chk("bp_pend_done", 32'(PEND), 32'h00);

        // Set wins over clear on the granted bit
        do_reset();
        IN = 8'h08; tick();
        IN = 8'h00; exp_q.push_back(3'd3); exp_q.push_back(3'd3);
        tick(); chk("sw_out3", 32'(OUT), 32'd3);
        IN = 8'h08; tick();
        chk("sw_pend_kept", 32'(PEND), 32'h08);
        chk("sw_valid0", 32'(VALID), 32'd0);
        IN = 8'h00; tick();
        chk("sw_regrant", 32'(OUT), 32'd3);
        chk("sw_regrant_valid", 32'(VALID), 32'd1);
        tick(); chk("sw_pend_done", 32'(PEND), 32'h00);

        // EN gating, and EN=0 while BUSY still completes the handshake
        do_reset();
        EN = 1'b0; IN = 8'hFF; tick();
        chk("en0_pend", 32'(PEND), 32'h00);
        tick(); chk("en0_valid", 32'(VALID), 32'd0);
        EN = 1'b1; IN = 8'h10; tick();
        IN = 8'h00; EN = 1'b0; exp_q.push_back(3'd4);
        tick(); chk("en0_busy_out", 32'(OUT), 32'd4);
        IN = 8'hFF; tick();
        chk("en0_busy_pend", 32'(PEND), 32'h00);
        chk("en0_busy_done", 32'(VALID), 32'd0);
        IN = 8'h00; EN = 1'b1;

        // All eight pending: strict order over 16 cycles
        do_reset();
        IN = 8'hFF; tick();
        IN = 8'h00;
        for (int i = 7; i >= 0; i--) exp_q.push_back(3'(i));
        repeat (16) tick();
        chk("all8_pend", 32'(PEND), 32'h00);
        chk("all8_valid", 32'(VALID), 32'd0);

        // Re-pulse after granting 0
        exp_q.push_back(3'd7); exp_q.push_back(3'd0);
        IN = 8'h81; tick();
        IN = 8'h00; repeat (4) tick();
        chk("rp0_pend", 32'(PEND), 32'h00);

        // Re-pulse after granting 1: pointer dependence only when rotating
        exp_q.push_back(3'd1);
        IN = 8'h02; tick();
        IN = 8'h00; repeat (2) tick();
`ifdef ROUND_ROBIN_EN
        exp_q.push_back(3'd0); exp_q.push_back(3'd7);
`else
        exp_q.push_back(3'd7); exp_q.push_back(3'd0);
`endif
        IN = 8'h81; tick();
        IN = 8'h00; repeat (4) tick();
        chk("rp1_pend", 32'(PEND), 32'h00);
        chk("sb_final_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
